// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 8-bit ALU: fetch, decode, operand read from an
// internal 8x8 register file, req/ack data-memory access, write-back and PC update.
module alu_issue_ctrl #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    input  logic [8:0]      instr_in,
    output logic [2:0]      alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic [7:0]      alu_out,
    input  logic            alu_zero,
    output logic            mem_req,
    output logic            mem_we,
    output logic [7:0]      mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    input  logic            mem_ack,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_STP, OP_SHF, OP_BNEG, OP_NOR, OP_ADD, OP_ADDI, OP_ST, OP_LD
    } op_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [8:0]      r_ir;
    logic [7:0]      r_rf [8];
    logic [7:0]      r_res;
    logic            r_z;

    op_t             w_op;
    logic [2:0]      w_rs;
    logic [2:0]      w_rt;
    logic [2:0]      w_sh_reg;
    logic            w_is_mem;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_one;

    assign w_op       = op_t'(r_ir[8:6]);
    assign w_rs       = r_ir[5:3];
    assign w_rt       = r_ir[2:0];
    assign w_sh_reg   = {1'b0, r_ir[5:4]};
    assign w_is_mem   = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_br_off   = {{(PC_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_one      = {{(PC_W-1){1'b0}}, 1'b1};
    assign instr_addr = r_pc;

    // Result register doubles as the load-data holding register for ld.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_PC;
            r_ir    <= '0;
            r_res   <= '0;
            r_z     <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_HALT: if (start) r_pc <= START_PC;
                S_FETCH: r_ir <= instr_in;
                S_EXEC: begin
                    r_res <= alu_out;
                    r_z   <= alu_zero;
                end
                S_MEM: if (mem_ack && (w_op == OP_LD)) r_res <= mem_rdata;
                S_WB: begin
                    case (w_op)
                        OP_ADD, OP_NOR, OP_ADDI, OP_LD: r_rf[w_rs] <= r_res;
                        OP_SHF:                         r_rf[w_sh_reg] <= r_res;
                        default: ;
                    endcase
                    r_pc <= ((w_op == OP_BNEG) && r_z) ? r_pc + w_br_off : r_pc + w_one;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_EXEC;
            S_EXEC: begin
                if (w_op == OP_STP)  w_next = S_HALT;
                else if (w_is_mem)   w_next = S_MEM;
                else                 w_next = S_WB;
            end
            S_MEM:   if (mem_ack) w_next = S_WB;
            S_WB:    w_next = S_FETCH;
            S_HALT:  if (start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = (r_state == S_HALT);
        if (r_state == S_EXEC) begin
            alu_op = w_is_mem ? OP_ADD : w_op;
            case (w_op)
                OP_ADD, OP_NOR: begin
                    alu_a = r_rf[w_rs];
                    alu_b = r_rf[w_rt];
                end
                OP_ADDI: begin
                    alu_a = r_rf[w_rs];
                    alu_b = {5'b0, w_rt};
                end
                OP_SHF: begin
                    alu_a = r_rf[w_sh_reg];
                    alu_b = {4'b0, r_ir[3:0]};
                end
                OP_BNEG:      alu_a = r_rf[0];
                OP_LD, OP_ST: alu_a = r_rf[w_rt];
                default: ;
            endcase
        end
        if (r_state == S_MEM) begin
            mem_req   = 1'b1;
            mem_we    = (w_op == OP_ST);
            mem_addr  = r_res;
            mem_wdata = r_rf[w_rs];
        end
    end

endmodule
